// File: rtl/mux_pipe_nto1_pkg.sv
// ============================================================================
// Module   : mux_pipe_nto1_pkg
// Purpose  : Shared constants for the registered N:1 mux and its skid buffer.
//            Holds the skid-buffer state encodings and the NUM_IN legality check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_pipe_nto1_pkg;

  // Skid-buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Supported input counts for the selector
  function automatic bit num_in_legal(input int n);
    return (n >= 2) && (n <= 16);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_skid_buf.sv
// ============================================================================
// Module   : mux_skid_buf
// Purpose  : Generic 2-entry skid buffer (main register M, skid register S).
//            Outputs come straight from M. in_ready depends only on the
//            occupancy state, so there is no out_ready -> in_ready path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_skid_buf
  import mux_pipe_nto1_pkg::*;
#(
  parameter int WIDTH_TOTAL = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_TOTAL-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH_TOTAL-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  logic [1:0]             state_q, state_d;
  logic [WIDTH_TOTAL-1:0] m_q, m_d;
  logic [WIDTH_TOTAL-1:0] s_q, s_d;
  logic                   w_accept;
  logic                   w_transfer;

  // in_ready is held low while reset is asserted, otherwise it reflects only
  // whether the skid slot is still free.
  assign in_ready   = !rst && (state_q != ST_FULL);
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_data   = m_q;
  assign w_accept   = in_valid && in_ready;
  assign w_transfer = out_valid && out_ready;

  // Next-state and register-load decisions for the occupancy FSM
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          m_d     = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (w_accept && w_transfer) begin
          m_d = in_data;
        end else if (w_accept) begin
          s_d     = in_data;
          state_d = ST_FULL;
        end else if (w_transfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Upstream is blocked here; only the downstream drain moves data.
        if (w_transfer) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State and data registers; reset discards any held words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_pipe_nto1.sv
// ============================================================================
// Module   : mux_pipe_nto1
// Purpose  : N:1 WIDTH-bit word mux with a registered 2-entry skid output
//            stage and valid/ready handshakes on both sides. Out-of-range
//            selects pass an all-zero word and set a sticky sel_err flag.
// Options  : MUX_PIPE_PARITY_EN adds out_parity (XOR of the stored word).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_pipe_nto1
  import mux_pipe_nto1_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef MUX_PIPE_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  generate
    if (!num_in_legal(NUM_IN)) begin : g_num_in_check
      $error("mux_pipe_nto1: NUM_IN must be within 2..16");
    end
  endgenerate

`ifdef MUX_PIPE_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int PAYLOAD_W = PAR_W + SEL_W + WIDTH;

  logic [WIDTH-1:0]     w_word;
  logic                 w_sel_bad;
  logic                 w_accept;
  logic [PAYLOAD_W-1:0] w_payload_in;
  logic [PAYLOAD_W-1:0] w_payload_out;
  logic                 sel_err_q, sel_err_d;

  // Word selector; any index without a matching input yields zero
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Extra bit so NUM_IN itself is representable when it is a power of two
  assign w_sel_bad = ({1'b0, sel} >= (SEL_W + 1)'(NUM_IN));
  assign w_accept  = in_valid && in_ready;

`ifdef MUX_PIPE_PARITY_EN
  assign w_payload_in                    = {^w_word, sel, w_word};
  assign {out_parity, out_sel, out_data} = w_payload_out;
`else
  assign w_payload_in        = {sel, w_word};
  assign {out_sel, out_data} = w_payload_out;
`endif

  mux_skid_buf #(
    .WIDTH_TOTAL (PAYLOAD_W)
  ) u_skid (
    .clk       (Clk),
    .rst       (Reset),
    .in_data   (w_payload_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (w_payload_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Sticky error: set only when a bad select is actually accepted
  always_comb begin
    sel_err_d = sel_err_q | (w_accept & w_sel_bad);
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_pipe_nto1.sv
// ============================================================================
// Module   : tb_mux_pipe_nto1
// Purpose  : Self-checking bench for mux_pipe_nto1 (NUM_IN=4 and NUM_IN=3).
//            Table-driven streaming/stall vectors, hand-written corner
//            sequences, and randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_pipe_nto1;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  // NUM_IN = 4 instance
  logic [127:0] d4_in;
  logic [1:0]   d4_sel, d4_osel;
  logic         d4_vld, d4_ordy, d4_irdy, d4_ovld, d4_err;
  logic [31:0]  d4_out;
  // NUM_IN = 3 instance
  logic [95:0]  d3_in;
  logic [1:0]   d3_sel, d3_osel;
  logic         d3_vld, d3_ordy, d3_irdy, d3_ovld, d3_err;
  logic [31:0]  d3_out;
`ifdef MUX_PIPE_PARITY_EN
  logic         d4_par, d3_par;
`endif

  mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
    .Clk(Clk), .Reset(Reset), .in_data(d4_in), .sel(d4_sel),
    .in_valid(d4_vld), .in_ready(d4_irdy), .out_data(d4_out),
    .out_sel(d4_osel), .out_valid(d4_ovld), .out_ready(d4_ordy),
    .sel_err(d4_err)
`ifdef MUX_PIPE_PARITY_EN
    , .out_parity(d4_par)
`endif
  );

  mux_pipe_nto1 #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .in_data(d3_in), .sel(d3_sel),
    .in_valid(d3_vld), .in_ready(d3_irdy), .out_data(d3_out),
    .out_sel(d3_osel), .out_valid(d3_ovld), .out_ready(d3_ordy),
    .sel_err(d3_err)
`ifdef MUX_PIPE_PARITY_EN
    , .out_parity(d3_par)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic        ordy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
    logic        exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[10];
  ent_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle and land 1 time unit after the rising edge
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Mid-cycle asynchronous reset; called 1 unit after a rising edge
  task automatic pulse_reset();
    d4_vld = 1'b0;
    d3_vld = 1'b0;
    #3;
    Reset = 1'b1;
    #1;
    chk("rst d4 out_valid", d4_ovld, 0);
    chk("rst d4 out_data",  d4_out,  0);
    chk("rst d4 out_sel",   d4_osel, 0);
    chk("rst d4 sel_err",   d4_err,  0);
    chk("rst d4 in_ready",  d4_irdy, 0);
    chk("rst d3 out_valid", d3_ovld, 0);
    chk("rst d3 sel_err",   d3_err,  0);
    chk("rst d3 in_ready",  d3_irdy, 0);
`ifdef MUX_PIPE_PARITY_EN
    chk("rst d4 out_parity", d4_par, 0);
`endif
    #2;
    Reset = 1'b0;
    #1;
    chk("post-rst d4 in_ready", d4_irdy, 1);
    chk("post-rst d3 in_ready", d3_irdy, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        acc, xfer, err_m;
    ent_t        e;
    int          sidx;

    // vld sel ordy | valid data sel ready (outputs after the edge)
    tbl[0] = '{1'b1, 2'd0, 1'b1, 1'b1, 32'h11111111, 2'd0, 1'b1};
    tbl[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h22222222, 2'd1, 1'b1};
    tbl[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h33333333, 2'd2, 1'b1};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h44444444, 2'd3, 1'b1};
    tbl[4] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1};
    tbl[5] = '{1'b1, 2'd2, 1'b0, 1'b1, 32'h33333333, 2'd2, 1'b1};
    tbl[6] = '{1'b1, 2'd3, 1'b0, 1'b1, 32'h33333333, 2'd2, 1'b0};
    tbl[7] = '{1'b1, 2'd0, 1'b0, 1'b1, 32'h33333333, 2'd2, 1'b0};
    tbl[8] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h44444444, 2'd3, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h00000000, 2'd0, 1'b1};

    d4_in   = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    d3_in   = {32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    d4_sel  = 2'd0; d4_vld = 1'b0; d4_ordy = 1'b1;
    d3_sel  = 2'd0; d3_vld = 1'b0; d3_ordy = 1'b1;
    step();
    step();
    pulse_reset();

    // Streaming and stall/skid on the 4-input instance
    for (int i = 0; i < 10; i++) begin
      d4_vld  = tbl[i].vld;
      d4_sel  = tbl[i].sel;
      d4_ordy = tbl[i].ordy;
      step();
      chk($sformatf("tbl[%0d] out_valid", i), d4_ovld, tbl[i].exp_valid);
      chk($sformatf("tbl[%0d] in_ready", i),  d4_irdy, tbl[i].exp_ready);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl[%0d] out_data", i), d4_out,  tbl[i].exp_data);
        chk($sformatf("tbl[%0d] out_sel", i),  d4_osel, tbl[i].exp_sel);
      end
    end
    d4_vld = 1'b0;

    // Bad select offered while FULL must not be captured nor flagged
    d3_ordy = 1'b0; d3_vld = 1'b1; d3_sel = 2'd0;
    step();
    d3_sel = 2'd1;
    step();
    chk("d3 full in_ready", d3_irdy, 0);
    d3_sel = 2'd3;
    step();
    chk("d3 blocked bad sel_err", d3_err, 0);
    chk("d3 full hold data", d3_out, 32'hA0A0A0A0);
    d3_vld = 1'b0; d3_ordy = 1'b1;
    step();
    chk("d3 drain second", d3_out, 32'hB1B1B1B1);
    step();
    chk("d3 drained valid", d3_ovld, 0);

    // Accepted bad select: zero word, raw sel, sticky error
    d3_vld = 1'b1; d3_sel = 2'd3;
    step();
    chk("bad out_valid", d3_ovld, 1);
    chk("bad out_data",  d3_out,  0);
    chk("bad out_sel",   d3_osel, 3);
    chk("bad sel_err",   d3_err,  1);
    d3_sel = 2'd1;
    step();
    chk("after bad out_data", d3_out, 32'hB1B1B1B1);
    chk("after bad sel_err",  d3_err, 1);
    d3_vld = 1'b0;
    step();
    chk("idle sel_err sticky", d3_err, 1);
    pulse_reset();

    // Reset while FULL discards both held words
    d4_ordy = 1'b0; d4_vld = 1'b1; d4_sel = 2'd2;
    step();
    d4_sel = 2'd3;
    step();
    chk("pre-rst full in_ready", d4_irdy, 0);
    chk("pre-rst full out_data", d4_out, 32'h33333333);
    pulse_reset();
    d4_ordy = 1'b1; d4_vld = 1'b1; d4_sel = 2'd1;
    step();
    chk("post-rst out_valid", d4_ovld, 1);
    chk("post-rst out_data",  d4_out,  32'h22222222);
    chk("post-rst out_sel",   d4_osel, 1);
    d4_vld = 1'b0;
    step();
    chk("post-rst no stale", d4_ovld, 0);

`ifdef MUX_PIPE_PARITY_EN
    d4_in = {32'h44444444, 32'h33333333, 32'h00000003, 32'h00000007};
    d4_vld = 1'b1; d4_sel = 2'd0;
    step();
    chk("parity 0x7", d4_par, 1);
    d4_sel = 2'd1;
    step();
    chk("parity 0x3", d4_par, 0);
    d4_vld = 1'b0;
    step();
`endif

    // Randomized traffic on the 3-input instance against a 2-deep FIFO model
    pulse_reset();
    err_m = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      d3_in   = {$urandom(), $urandom(), $urandom()};
      d3_vld  = ($urandom_range(0, 3) != 0);
      d3_sel  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      d3_ordy = ((c / 64) % 2 == 1) ? ($urandom_range(0, 3) == 0)
                                    : ($urandom_range(0, 3) != 0);
      acc  = d3_vld && (q.size() < 2);
      xfer = (q.size() > 0) && d3_ordy;
      sidx = int'(d3_sel);
      e.sel  = d3_sel;
      e.data = (sidx < 3) ? d3_in[sidx*32 +: 32] : 32'h0;
      step();
      if (xfer) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (sidx >= 3) err_m = 1'b1;
      end
      chk($sformatf("rnd[%0d] out_valid", c), d3_ovld, (q.size() > 0));
      chk($sformatf("rnd[%0d] in_ready", c),  d3_irdy, (q.size() < 2));
      chk($sformatf("rnd[%0d] sel_err", c),   d3_err,  err_m);
      if (q.size() > 0) begin
        chk($sformatf("rnd[%0d] out_data", c), d3_out,  q[0].data);
        chk($sformatf("rnd[%0d] out_sel", c),  d3_osel, q[0].sel);
`ifdef MUX_PIPE_PARITY_EN
        chk($sformatf("rnd[%0d] out_parity", c), d3_par, ^q[0].data);
`endif
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
